// File: rtl/csr_file_m.sv
// csr_file_m -- machine-mode CSR file for the rv32 core.
//
// Purpose: CSRRW/CSRRS/CSRRC access to the M-mode CSRs, 64-bit cycle, instret
//   and HPM counters gated by mcountinhibit, trap entry / MRET sequencing,
//   vectored mtvec and interrupt-pending evaluation.
//
// Ports:
//   clk, rst_n              core clock, async active-low reset
//   csr_en/csr_op/csr_nowr  CSR access strobe, op (01 RW, 10 RS, 11 RC, 00 read),
//                           zero rs1/uimm (suppresses RS/RC write)
//   address, wrdata         CSR address and operand
//   rdata, illegal          old CSR value and illegal-access flag (combinational)
//   pc, trap, trap_cause,
//   trap_tval, mret         trap entry / MRET retire controls
//   instret, hpm_evt        counter event pulses
//   xEIP, xTIP, xSIP        interrupt request levels
//   irq_pending             enabled interrupt pending (combinational)
//   trap_vector             trap target PC (combinational)
//   o_mepc                  mepc, MRET target

// One counter: CNT_W implemented bits, presented as a zero-extended 64-bit
// value. A half write replaces that half and suppresses the increment.
module csr_cnt_m #(
   parameter int CNT_W = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] value
);
   logic [CNT_W-1:0] cnt;
   logic [63:0]      wr_val;
   logic             unused;

   assign value  = 64'(cnt);
   assign unused = ^wr_val;

   always_comb begin
      wr_val = value;
      if (wr_lo) wr_val[31:0]  = wdata;
      if (wr_hi) wr_val[63:32] = wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              cnt <= '0;
      else if (wr_lo || wr_hi) cnt <= wr_val[CNT_W-1:0];
      else if (inc)            cnt <= cnt + CNT_W'(1);
   end
endmodule

module csr_file_m #(
   parameter logic [31:0] MHARTID   = 32'd0,
   parameter logic [31:0] MVENDORID = 32'd0,
   parameter logic [31:0] MARCHID   = 32'd0,
   parameter int          NUM_HPM   = 4,
   parameter int          CNT_W     = 64
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  csr_en,
   input  logic [1:0]                            csr_op,
   input  logic                                  csr_nowr,
   input  logic [11:0]                           address,
   input  logic [31:0]                           wrdata,
   output logic [31:0]                           rdata,
   output logic                                  illegal,
   input  logic [31:0]                           pc,
   input  logic                                  trap,
   input  logic [31:0]                           trap_cause,
   input  logic [31:0]                           trap_tval,
   input  logic                                  mret,
   input  logic                                  instret,
   input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_evt,
   input  logic                                  xEIP,
   input  logic                                  xTIP,
   input  logic                                  xSIP,
   output logic                                  irq_pending,
   output logic [31:0]                           trap_vector,
   output logic [31:0]                           o_mepc
);
   // Counter slots: 0 = cycle, 1 = instret, 2+i = HPM i.
   localparam int          NUM_CNT   = NUM_HPM + 2;
   localparam logic [63:0] HPM_BITS  = ((64'd1 << NUM_HPM) - 64'd1) << 3;
   localparam logic [31:0] CINH_MASK = HPM_BITS[31:0] | 32'h5;

   // Architectural state
   logic        st_mie, st_mpie;
   logic        ie_me, ie_mt, ie_ms;
   logic        ip_ms;
   logic [29:0] mtvec_base;
   logic        mtvec_mode;
   logic [29:0] mepc;
   logic [31:0] mcause, mtval, mscratch, mcountinhibit;

   // Read views
   logic [31:0] mstatus_rd, mie_rd, mip_rd;
   logic [31:0] csr_val, old_val, wr_new;
   logic        csr_hit, cnt_hit, any_hit;
   logic        does_wr, ro_wr, bad_acc, commit;
   logic        unused;

   assign mstatus_rd = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};
   assign mie_rd     = {20'b0, ie_me, 3'b0, ie_mt, 3'b0, ie_ms, 3'b0};
   assign mip_rd     = {20'b0, xEIP, 3'b0, xTIP, 3'b0, ip_ms | xSIP, 3'b0};
   assign unused     = ^pc[1:0];

   // ---------------------------------------------------------------- counters
   logic                        cnt_space;
   logic [NUM_CNT-1:0]          cnt_sel, cnt_inc, cnt_wr_lo, cnt_wr_hi;
   logic [NUM_CNT-1:0][63:0]    cnt_val;
   logic [NUM_CNT-1:0][31:0]    cnt_rd;
   logic [NUM_CNT:0][31:0]      cnt_or;

   // B/C pages with address[6:5]=0; address[7] picks the high half.
   assign cnt_space = ((address[11:8] == 4'hB) || (address[11:8] == 4'hC)) &&
                      (address[6:5] == 2'b00);
   assign cnt_or[0] = '0;

   genvar k;
   generate
      for (k = 0; k < NUM_CNT; k++) begin : g_cnt
         localparam logic [4:0] AIDX = (k == 0) ? 5'd0 : (k == 1) ? 5'd2 : 5'(k + 1);
         localparam int         CBIT = (k == 0) ? 0 : k + 1;

         assign cnt_sel[k]   = cnt_space && (address[4:0] == AIDX);
         assign cnt_wr_lo[k] = commit && cnt_sel[k] && !address[7];
         assign cnt_wr_hi[k] = commit && cnt_sel[k] &&  address[7];
         assign cnt_rd[k]    = !cnt_sel[k] ? 32'd0 :
                               address[7] ? cnt_val[k][63:32] : cnt_val[k][31:0];
         assign cnt_or[k+1]  = cnt_or[k] | cnt_rd[k];

         if (k == 0) begin : g_cy
            assign cnt_inc[k] = !mcountinhibit[CBIT];
         end else if (k == 1) begin : g_ir
            assign cnt_inc[k] = instret && !mcountinhibit[CBIT];
         end else begin : g_hpm
            assign cnt_inc[k] = hpm_evt[k-2] && !mcountinhibit[CBIT];
         end

         csr_cnt_m #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_inc[k]),
            .wr_lo (cnt_wr_lo[k]),
            .wr_hi (cnt_wr_hi[k]),
            .wdata (wr_new),
            .value (cnt_val[k])
         );
      end
   endgenerate

   assign cnt_hit = |cnt_sel;

   // ------------------------------------------------------------ read decode
   always_comb begin
      csr_hit = 1'b1;
      csr_val = 32'd0;
      case (address)
         12'h300: csr_val = mstatus_rd;
         12'h301: csr_val = 32'h4000_0100;
         12'h304: csr_val = mie_rd;
         12'h305: csr_val = {mtvec_base, 1'b0, mtvec_mode};
         12'h320: csr_val = mcountinhibit;
         12'h340: csr_val = mscratch;
         12'h341: csr_val = {mepc, 2'b00};
         12'h342: csr_val = mcause;
         12'h343: csr_val = mtval;
         12'h344: csr_val = mip_rd;
         12'hF11: csr_val = MVENDORID;
         12'hF12: csr_val = MARCHID;
         12'hF14: csr_val = MHARTID;
         default: csr_hit = 1'b0;
      endcase
   end

   assign any_hit = csr_hit | cnt_hit;
   assign old_val = csr_val | cnt_or[NUM_CNT];

   // RS/RC with a zero operand are pure reads, so they may touch read-only CSRs.
   assign does_wr = (csr_op == 2'b01) || (csr_op[1] && !csr_nowr);
   assign ro_wr   = (address[11:10] == 2'b11) && does_wr;
   assign bad_acc = !any_hit || ro_wr;
   assign illegal = csr_en && bad_acc;
   assign rdata   = bad_acc ? 32'd0 : old_val;

   // Trap and MRET own the edge; a concurrent CSR write is dropped.
   assign commit  = csr_en && does_wr && !bad_acc && !trap && !mret;

   always_comb begin
      case (csr_op)
         2'b01:   wr_new = wrdata;
         2'b10:   wr_new = old_val | wrdata;
         2'b11:   wr_new = old_val & ~wrdata;
         default: wr_new = old_val;
      endcase
   end

   // ------------------------------------------------------------ state update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_mie        <= 1'b0;
         st_mpie       <= 1'b0;
         ie_me         <= 1'b0;
         ie_mt         <= 1'b0;
         ie_ms         <= 1'b0;
         ip_ms         <= 1'b0;
         mtvec_base    <= '0;
         mtvec_mode    <= 1'b0;
         mepc          <= '0;
         mcause        <= '0;
         mtval         <= '0;
         mscratch      <= '0;
         mcountinhibit <= '0;
      end else if (trap) begin
         mepc    <= pc[31:2];
         mcause  <= trap_cause;
         mtval   <= trap_tval;
         st_mpie <= st_mie;
         st_mie  <= 1'b0;
      end else if (mret) begin
         st_mie  <= st_mpie;
         st_mpie <= 1'b1;
      end else if (commit) begin
         case (address)
            12'h300: begin
               st_mie  <= wr_new[3];
               st_mpie <= wr_new[7];
            end
            12'h304: begin
               ie_me <= wr_new[11];
               ie_mt <= wr_new[7];
               ie_ms <= wr_new[3];
            end
            12'h305: begin
               mtvec_base <= wr_new[31:2];
               mtvec_mode <= wr_new[0];
            end
            12'h320: mcountinhibit <= wr_new & CINH_MASK;
            12'h340: mscratch      <= wr_new;
            12'h341: mepc          <= wr_new[31:2];
            12'h342: mcause        <= wr_new;
            12'h343: mtval         <= wr_new;
            12'h344: ip_ms         <= wr_new[3];
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- outputs
   assign irq_pending = st_mie && |(mip_rd & mie_rd);
   assign o_mepc      = {mepc, 2'b00};
   assign trap_vector = (mtvec_mode && trap_cause[31]) ?
                        {mtvec_base, 2'b00} + {25'd0, trap_cause[4:0], 2'b00} :
                        {mtvec_base, 2'b00};
endmodule

// File: tb/tb_csr_file_m.sv
module tb_csr_file_m;
   localparam int NHPM = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            csr_en, csr_nowr, trap, mret, instret;
   logic [1:0]      csr_op;
   logic [11:0]     address;
   logic [31:0]     wrdata, pc, trap_cause, trap_tval;
   logic [NHPM-1:0] hpm_evt;
   logic            xEIP, xTIP, xSIP;
   logic [31:0]     rdata, trap_vector, o_mepc;
   logic            illegal, irq_pending;

   csr_file_m #(.NUM_HPM(NHPM), .CNT_W(64)) dut (
      .clk(clk), .rst_n(rst_n), .csr_en(csr_en), .csr_op(csr_op),
      .csr_nowr(csr_nowr), .address(address), .wrdata(wrdata), .rdata(rdata),
      .illegal(illegal), .pc(pc), .trap(trap), .trap_cause(trap_cause),
      .trap_tval(trap_tval), .mret(mret), .instret(instret), .hpm_evt(hpm_evt),
      .xEIP(xEIP), .xTIP(xTIP), .xSIP(xSIP), .irq_pending(irq_pending),
      .trap_vector(trap_vector), .o_mepc(o_mepc)
   );

   always #5 clk = ~clk;

   // Expected-response scoreboard: entries are tagged with the cycle they
   // belong to and which output they check.
   typedef enum int {S_RD, S_ILL, S_IRQ, S_TV, S_MEPC} sel_t;
   typedef struct {
      int          cyc;
      sel_t        sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   n_run = 0;
   int   n_fail = 0;
   bit   done = 1'b0;

   always @(posedge clk) cyc++;

   // Monitor: on each falling edge, check every expectation due this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] act;
         e = q.pop_front();
         case (e.sel)
            S_RD:    act = rdata;
            S_ILL:   act = {31'd0, illegal};
            S_IRQ:   act = {31'd0, irq_pending};
            S_TV:    act = trap_vector;
            default: act = o_mepc;
         endcase
         n_run++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: stale check (cycle %0d, now %0d)", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
         end
      end
   end

   task automatic exp_push(input sel_t s, input logic [31:0] v, input string nm);
      exp_t e;
      e.cyc = cyc; e.sel = s; e.val = v; e.name = nm;
      q.push_back(e);
   endtask

   // Advance to just after the next rising edge, dropping pulse inputs.
   task automatic step();
      @(posedge clk); #1;
      csr_en = 1'b0; csr_op = 2'b00; csr_nowr = 1'b0; address = '0; wrdata = '0;
      trap = 1'b0; mret = 1'b0; instret = 1'b0; hpm_evt = '0;
   endtask

   task automatic acc(input logic [1:0] op, input logic nowr, input logic [11:0] a,
                      input logic [31:0] wd);
      csr_en = 1'b1; csr_op = op; csr_nowr = nowr; address = a; wrdata = wd;
   endtask

   // Access plus rdata/illegal expectations in the same cycle.
   task automatic chk(input logic [1:0] op, input logic nowr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd,
                      input logic exp_ill, input string nm);
      acc(op, nowr, a, wd);
      exp_push(S_RD, exp_rd, nm);
      exp_push(S_ILL, {31'd0, exp_ill}, {nm, ".ill"});
   endtask

   initial begin
      rst_n = 1'b0; xEIP = 1'b0; xTIP = 1'b0; xSIP = 1'b0;
      pc = '0; trap_cause = '0; trap_tval = '0;
      csr_en = 1'b0; csr_op = 2'b00; csr_nowr = 1'b0; address = '0; wrdata = '0;
      trap = 1'b0; mret = 1'b0; instret = 1'b0; hpm_evt = '0;
      repeat (3) @(posedge clk);

      // Reset state and free-running mcycle
      @(posedge clk); #1; rst_n = 1'b1;
      chk(2'b00, 0, 12'hB00, 0, 32'd0, 0, "mcycle0");
      exp_push(S_IRQ, 0, "rst.irq"); exp_push(S_TV, 0, "rst.tv"); exp_push(S_MEPC, 0, "rst.mepc");
      step(); chk(2'b00, 0, 12'hB00, 0, 32'd1, 0, "mcycle1");
      step(); chk(2'b00, 0, 12'hB00, 0, 32'd2, 0, "mcycle2");
      step(); chk(2'b01, 0, 12'hB00, 32'hFFFF_FFFF, 32'd3, 0, "mcycle.wr");
      step(); chk(2'b00, 0, 12'hB80, 0, 32'd0, 0, "mcycleh.nocarry");
      step(); chk(2'b00, 0, 12'hB80, 0, 32'd1, 0, "mcycleh.carry");

      // mstatus set/clear
      step(); chk(2'b10, 0, 12'h300, 32'h8, 32'h1800, 0, "mstatus.rs");
      step(); chk(2'b00, 0, 12'h300, 0, 32'h1808, 0, "mstatus.mie");
      step(); chk(2'b11, 1, 12'h300, 32'h8, 32'h1808, 0, "mstatus.rc_nowr");
      step(); chk(2'b00, 0, 12'h300, 0, 32'h1808, 0, "mstatus.hold");

      // Vectored trap entry with a dropped concurrent write
      step(); chk(2'b01, 0, 12'h305, 32'h1001, 32'd0, 0, "mtvec.wr");
      step(); chk(2'b01, 0, 12'h304, 32'h80, 32'd0, 0, "mie.wr");
      step(); xTIP = 1'b1;
      chk(2'b00, 0, 12'h305, 0, 32'h1001, 0, "mtvec.rd");
      exp_push(S_IRQ, 1, "irq.tip");
      step(); chk(2'b00, 0, 12'h344, 0, 32'h80, 0, "mip.tip");
      step(); trap = 1'b1; trap_cause = 32'h8000_0007; pc = 32'h200; trap_tval = 32'hDEAD;
      chk(2'b01, 0, 12'h340, 32'h55, 32'd0, 0, "trap.csr");
      exp_push(S_TV, 32'h101C, "trap.vec");
      step(); chk(2'b00, 0, 12'h300, 0, 32'h1880, 0, "trap.mstatus");
      exp_push(S_IRQ, 0, "trap.irq"); exp_push(S_MEPC, 32'h200, "trap.mepc");
      step(); chk(2'b00, 0, 12'h342, 0, 32'h8000_0007, 0, "mcause");
      step(); chk(2'b00, 0, 12'h343, 0, 32'hDEAD, 0, "mtval");
      step(); chk(2'b00, 0, 12'h340, 0, 32'd0, 0, "mscratch.dropped");

      // MRET
      step(); mret = 1'b1;
      step(); chk(2'b00, 0, 12'h300, 0, 32'h1888, 0, "mret.mstatus");
      exp_push(S_MEPC, 32'h200, "mret.mepc"); exp_push(S_IRQ, 1, "mret.irq");
      step(); xTIP = 1'b0; trap_cause = 32'd2;
      chk(2'b00, 0, 12'h341, 0, 32'h200, 0, "mepc.rd");
      exp_push(S_IRQ, 0, "irq.notip"); exp_push(S_TV, 32'h1000, "tv.exc");

      // Illegal accesses
      step(); chk(2'b01, 0, 12'hC00, 32'd5, 32'd0, 1, "ill.wr_c00");
      step(); chk(2'b00, 0, 12'hB05, 0, 32'd0, 1, "ill.b05");
      step(); chk(2'b00, 0, 12'h7C0, 0, 32'd0, 1, "ill.7c0");
      step(); chk(2'b01, 0, 12'hC02, 32'd7, 32'd0, 1, "ill.wr_c02");
      step(); chk(2'b10, 0, 12'hF11, 32'd1, 32'd0, 1, "ill.rs_f11");
      step(); chk(2'b10, 1, 12'hF11, 32'd1, 32'd0, 0, "f11.rs_nowr");
      step(); chk(2'b00, 0, 12'hC02, 0, 32'd0, 0, "instret.unchanged");
      step(); chk(2'b00, 0, 12'hB04, 0, 32'd0, 0, "hpm1.legal");
      step(); chk(2'b00, 0, 12'h301, 0, 32'h4000_0100, 0, "misa");

      // WARL masks
      step(); chk(2'b01, 0, 12'h341, 32'h303, 32'h200, 0, "mepc.wr");
      step(); chk(2'b00, 0, 12'h341, 0, 32'h300, 0, "mepc.mask");
      exp_push(S_MEPC, 32'h300, "mepc.out");
      step(); chk(2'b01, 0, 12'h344, 32'hFFFF_FFFF, 32'd0, 0, "mip.wr");
      step(); chk(2'b00, 0, 12'h344, 0, 32'h8, 0, "mip.msip");
      exp_push(S_IRQ, 0, "irq.msie_off");
      step(); chk(2'b01, 0, 12'h304, 32'hFFFF_FFFF, 32'h80, 0, "mie.wrall");
      step(); chk(2'b00, 0, 12'h304, 0, 32'h888, 0, "mie.mask");
      exp_push(S_IRQ, 1, "irq.msip");
      step(); xEIP = 1'b1; chk(2'b00, 0, 12'h344, 0, 32'h808, 0, "mip.meip");
      step(); chk(2'b11, 0, 12'h344, 32'h8, 32'h808, 0, "mip.rc");
      step(); xSIP = 1'b1; chk(2'b00, 0, 12'h344, 0, 32'h808, 0, "mip.xsip");
      step(); xEIP = 1'b0; xSIP = 1'b0;

      // mcountinhibit
      chk(2'b01, 0, 12'h320, 32'hFFFF_FFFF, 32'd0, 0, "cinh.wr");
      step(); chk(2'b01, 0, 12'h320, 32'h4, 32'h1D, 0, "cinh.mask");
      step(); instret = 1'b1;
      step(); instret = 1'b1;
      step(); instret = 1'b1;
      step(); chk(2'b00, 0, 12'hB02, 0, 32'd0, 0, "minstret.inh");
      step(); chk(2'b01, 0, 12'h320, 32'd0, 32'h4, 0, "cinh.clr");
      step(); instret = 1'b1;
      step(); chk(2'b00, 0, 12'hB02, 0, 32'd1, 0, "minstret.inc");

      // HPM: 64-bit wrap, inhibit, write-cycle suppression
      step(); chk(2'b01, 0, 12'hB03, 32'hFFFF_FFFF, 32'd0, 0, "hpm0.wrlo");
      step(); chk(2'b01, 0, 12'hB83, 32'hFFFF_FFFF, 32'd0, 0, "hpm0.wrhi");
      step(); hpm_evt = 2'b01; chk(2'b00, 0, 12'hB03, 0, 32'hFFFF_FFFF, 0, "hpm0.max");
      step(); chk(2'b00, 0, 12'hB03, 0, 32'd0, 0, "hpm0.wrap_lo");
      step(); chk(2'b00, 0, 12'hB83, 0, 32'd0, 0, "hpm0.wrap_hi");
      step(); hpm_evt = 2'b01; chk(2'b01, 0, 12'hB03, 32'd5, 32'd0, 0, "hpm0.wr_evt");
      step(); chk(2'b00, 0, 12'hC03, 0, 32'd5, 0, "hpm0.noinc");
      step(); chk(2'b01, 0, 12'h320, 32'h10, 32'd0, 0, "cinh.hpm1");
      step(); hpm_evt = 2'b10;
      step(); chk(2'b00, 0, 12'hB04, 0, 32'd0, 0, "hpm1.inh");
      step(); chk(2'b01, 0, 12'h320, 32'd0, 32'h10, 0, "cinh.clr2");
      step(); hpm_evt = 2'b10;
      step(); chk(2'b00, 0, 12'hB04, 0, 32'd1, 0, "hpm1.inc");

      // Reset mid-operation
      step(); rst_n = 1'b0; #2; rst_n = 1'b1;
      step(); chk(2'b00, 0, 12'h300, 0, 32'h1800, 0, "rst2.mstatus");
      exp_push(S_MEPC, 0, "rst2.mepc"); exp_push(S_TV, 0, "rst2.tv");
      step(); chk(2'b00, 0, 12'h304, 0, 32'd0, 0, "rst2.mie");
      step(); chk(2'b00, 0, 12'hB02, 0, 32'd0, 0, "rst2.minstret");
      step(); chk(2'b00, 0, 12'hB04, 0, 32'd0, 0, "rst2.hpm1");
      step(); step();
      done = 1'b1;
   end

   initial begin
      fork
         wait (done);
         begin
            repeat (5000) @(posedge clk);
            n_run++; n_fail++;
            $display("FAIL watchdog: stimulus incomplete, expected done=1");
         end
      join_any
      @(negedge clk); #1;
      if (q.size() != 0) begin
         n_run++; n_fail++;
         $display("FAIL scoreboard: %0d unchecked entries, expected 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
